// File: rtl/wb_regfile.sv
// Write-back register file: 32x32 array, two combinational read ports, commit counter.
// Optional same-cycle write-to-read bypass enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wbMemDataIn,
  input  logic [DATA_W-1:0] wbAluDataIn,
  input  logic [ADDR_W-1:0] wbRdIn,
  input  logic              wbMemToRegIn,
  input  logic              wbRegWriteIn,
  input  logic [ADDR_W-1:0] rs1Addr,
  input  logic [ADDR_W-1:0] rs2Addr,
  output logic [DATA_W-1:0] rs1Data,
  output logic [DATA_W-1:0] rs2Data,
  output logic [DATA_W-1:0] wbDataOut,
  output logic [31:0]       wbCount
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [31:0]       cnt_q;
  logic [31:0]       cnt_d;
  logic              commit;

  assign wbDataOut = wbMemToRegIn ? wbMemDataIn
                                  : wbAluDataIn;
  assign commit = wbRegWriteIn
                & (wbRdIn != '0)
                & rst;
  assign cnt_d   = cnt_q + 32'd1;
  assign wbCount = cnt_q;

  // Reset wins over a simultaneous commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (commit) begin
      regs_q[wbRdIn] <= wbDataOut;
      cnt_q          <= cnt_d;
    end
  end

  always_comb begin
    rs1Data = '0;
    if (rs1Addr != '0) begin
      rs1Data = regs_q[rs1Addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (commit && (rs1Addr == wbRdIn)) begin
        rs1Data = wbDataOut;
      end
`endif
    end
  end

  always_comb begin
    rs2Data = '0;
    if (rs2Addr != '0) begin
      rs2Data = regs_q[rs2Addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (commit && (rs2Addr == wbRdIn)) begin
        rs2Data = wbDataOut;
      end
`endif
    end
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the MEM/WB interface: a 32×32 register file that consumes the MEM/WB register outputs, selects memory or ALU data, commits it to the addressed register, and serves two combinational read ports to the decode stage. It also exports the selected write-back value for the forwarding network, and keeps a free-running count of committed writes for bring-up and performance checks.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; depth is 2**ADDR_W

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge, asserted when 0
- wbMemDataIn  input  DATA_W  load data from MEM/WB register
- wbAluDataIn  input  DATA_W  ALU result from MEM/WB register
- wbRdIn  input  ADDR_W  destination register
- wbMemToRegIn  input  1  1 selects wbMemDataIn, 0 selects wbAluDataIn
- wbRegWriteIn  input  1  write enable
- rs1Addr  input  ADDR_W  read port 1 address
- rs2Addr  input  ADDR_W  read port 2 address
- rs1Data  output  DATA_W  read port 1 data, combinational
- rs2Data  output  DATA_W  read port 2 data, combinational
- wbDataOut  output  DATA_W  selected write-back value, combinational, for forwarding
- wbCount  output  32  committed-write counter, registered

## Operation
- Write data: wbDataOut = wbMemToRegIn ? wbMemDataIn : wbAluDataIn; always driven, independent of wbRegWriteIn.
- Commit condition: wbRegWriteIn == 1 and wbRdIn != 0 and rst == 1.
- On commit, register[wbRdIn] <= wbDataOut at the rising edge.
- Register 0 hardwired: never written; reads of address 0 return 0 on both ports, including via bypass.
- Writes with wbRdIn == 0 are silently dropped and are not counted.
- wbCount increments by 1 on each commit; wraps 0xFFFFFFFF -> 0x00000000; no saturation, no overflow flag.
- Read ports: rsNData = register[rsNAddr] (0 for address 0), subject to bypass (see Configuration).
- Both read ports may address the same register, or the commit target, in the same cycle; each resolves independently.
- No stall or handshake: one commit per cycle at most; the MEM/WB register guarantees at most one write per cycle.

## Timing
- Reset: on a rising edge with rst == 0, all 2**ADDR_W registers clear to 0 and wbCount clears to 0. Reset has priority over a simultaneous commit (the write is lost, not counted).
- Reset values: rs1Data, rs2Data = 0 from the cycle after the reset edge (array cleared); wbDataOut follows its inputs combinationally; wbCount = 0.
- While rst == 0, bypass is suppressed; read ports return array contents.
- Write latency: value committed at edge N is visible from the array in the cycle after edge N.
- wbCount reflects commits through the most recent edge (1-cycle latency from commit condition).
- Reset released mid-stream: first commit is the first edge with rst == 1 and commit condition true.

## Configuration
- Macro WB_REGFILE_BYPASS_EN.
- Defined: if commit condition holds and rsNAddr == wbRdIn, rsNData = wbDataOut in the same cycle (write-before-read, same-cycle visibility); decode sees the value being written back without a stall.
- Undefined: no internal bypass; same-cycle read of the commit target returns the old array value; hazard/forwarding logic upstream must cover the extra cycle.
- wbCount and all other behaviour identical in both builds.

## Test plan
- Reset: drive rst=0 for 2 edges after writing 0xDEADBEEF to r5 -> r5 reads 0, wbCount = 0; commit during the rst=0 edge -> not written, not counted.
- Mux and commit: wbAluDataIn=0x11111111, wbMemDataIn=0x22222222, wbRdIn=7, wbMemToRegIn=1, wbRegWriteIn=1 for one edge -> wbDataOut=0x22222222, r7 = 0x22222222 next cycle, wbCount = 1.
- Register 0: commit 0xFFFFFFFF to rd=0 -> rs1Addr=0 reads 0, wbCount unchanged; with bypass build, same-cycle read of 0 also 0.
- Bypass: r3 = 0xA, commit 0xB to r3 with rs1Addr=rs2Addr=3 same cycle -> with WB_REGFILE_BYPASS_EN both read 0xB; without it both read 0xA, then 0xB next cycle.
- Write disabled: wbRegWriteIn=0, wbRdIn=9, data 0x55 -> r9 unchanged, wbCount unchanged, wbDataOut still 0x55.
- Counter wrap: force 2**32 commits (or preload via hierarchical deposit to 0xFFFFFFFF) then one commit -> wbCount = 0.
